// File: rtl/serv_bufreg_par_if.sv
// ---------------------------------------------------------------------------
// serv_bufreg_par_if
// Groups the beat-level control, operand and result signals of the
// parametrised SERV buffer register so the block and its driver connect
// through a single port.
//
// Signals (B = bits per beat):
//   i_en        beat strobe
//   i_init      1 = address-compute pass, 0 = shift/loop pass
//   i_loop      with i_init=0, recirculate o_q instead of loading the sum
//   i_rs1       [B]  rs1 bits for this beat, LSB first
//   i_rs1_en    gate for i_rs1
//   i_imm       [B]  immediate bits for this beat, LSB first
//   i_imm_en    gate for i_imm
//   i_clr_lsb   clear imm bit 0 on beat 0 (JALR)
//   i_size      [2]  00 byte, 01 half, 10/11 word
//   o_lsb       [2]  address bits [1:0] captured during an INIT pass
//   o_dbus_adr  [32] word-aligned data bus address
//   o_q         [B]  serial output, low bits of the register
//   o_done      one-cycle pulse after the last beat of a pass
//   o_misalign  access misalignment, updated at the end of INIT passes
//
// Modports: master drives i_* and observes o_*; slave is the register.
// ---------------------------------------------------------------------------
interface serv_bufreg_par_if #(
    parameter int B = 1
);
    logic         i_en;
    logic         i_init;
    logic         i_loop;
    logic [B-1:0] i_rs1;
    logic         i_rs1_en;
    logic [B-1:0] i_imm;
    logic         i_imm_en;
    logic         i_clr_lsb;
    logic [1:0]   i_size;

    logic [1:0]   o_lsb;
    logic [31:0]  o_dbus_adr;
    logic [B-1:0] o_q;
    logic         o_done;
    logic         o_misalign;

    modport master (
        output i_en, i_init, i_loop, i_rs1, i_rs1_en, i_imm, i_imm_en,
               i_clr_lsb, i_size,
        input  o_lsb, o_dbus_adr, o_q, o_done, o_misalign
    );

    modport slave (
        input  i_en, i_init, i_loop, i_rs1, i_rs1_en, i_imm, i_imm_en,
               i_clr_lsb, i_size,
        output o_lsb, o_dbus_adr, o_q, o_done, o_misalign
    );
endinterface

// File: rtl/serv_bufreg_par.sv
// ---------------------------------------------------------------------------
// serv_bufreg_par
// Buffer register for the bit-serial SERV datapath, processing B bits per
// beat (B = 1, 2, 4 or 8; 32/B beats per pass).
//   INIT pass : accumulates rs1 + imm serially into a 32-bit shift register,
//               giving the data bus address and its two LSBs.
//   LOOP pass : recirculates the register (shift ops) or reloads it.
// A beat counter marks the end of each pass with a one-cycle o_done pulse;
// a misalignment flag is derived from i_size and the captured LSBs.
//
// Ports:
//   i_clk  clock, all state changes on the rising edge
//   i_rst  synchronous active-high reset, overrides every other input
//   bus    serv_bufreg_par_if.slave (see interface for signal list)
//
// Beat handshake: there is no back-pressure. Each cycle with bus.i_en high
// is exactly one beat; the operands presented in that cycle are consumed at
// the rising edge. With i_en low nothing advances and the carry holds.
// ---------------------------------------------------------------------------
module serv_bufreg_par #(
    parameter int B = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    serv_bufreg_par_if.slave     bus
);
    localparam int BEATS = 32 / B;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    logic [31:0]      r_data;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_lsb;
    logic             r_done;
    logic             r_misalign;

    logic             w_last;
    logic [B-1:0]     w_rs1_m;
    logic [B-1:0]     w_imm_m;
    logic [B-1:0]     w_s;
    logic             w_c;
    logic [B-1:0]     w_nxt;
    logic             w_lsb_we;
    logic [1:0]       w_lsb_nxt;
    logic             w_misalign_nxt;

    assign w_last = (r_cnt == LAST);

    // Operand gating; JALR clears only the immediate's bit 0, never rs1.
    always_comb begin
        w_imm_m = bus.i_imm;
        if ((r_cnt == '0) && bus.i_clr_lsb) begin
            w_imm_m[0] = 1'b0;
        end
        w_imm_m = w_imm_m & {B{bus.i_imm_en}};
        w_rs1_m = bus.i_rs1 & {B{bus.i_rs1_en}};
    end

    assign {w_c, w_s} = {1'b0, w_rs1_m} + {1'b0, w_imm_m} + {{B{1'b0}}, r_carry};

    assign w_nxt = (bus.i_loop && !bus.i_init) ? r_data[B-1:0] : w_s;

    // With one bit per beat the two address LSBs arrive on beats 0 and 1;
    // wider beats deliver both on beat 0.
    generate
        if (B == 1) begin : g_lsb_serial
            assign w_lsb_we  = (r_cnt == CNT_W'(0)) || (r_cnt == CNT_W'(1));
            assign w_lsb_nxt = (r_cnt == CNT_W'(0)) ? {r_lsb[1], w_s[0]}
                                                    : {w_s[0], r_lsb[0]};
        end else begin : g_lsb_parallel
            assign w_lsb_we  = (r_cnt == '0);
            assign w_lsb_nxt = w_s[1:0];
        end
    endgenerate

    // The LSBs are final long before the last beat, so r_lsb can be used
    // directly when the INIT pass closes.
    assign w_misalign_nxt = ((bus.i_size == 2'b01) && r_lsb[0]) ||
                            (bus.i_size[1] && (|r_lsb));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data     <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_lsb      <= '0;
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_done <= bus.i_en && w_last;
            if (bus.i_en) begin
                r_data  <= {w_nxt, r_data[31:B]};
                r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
                // Carry is dropped on the last beat so every pass starts clean.
                r_carry <= (bus.i_init && !w_last) ? w_c : 1'b0;
                if (bus.i_init && w_lsb_we) begin
                    r_lsb <= w_lsb_nxt;
                end
                if (bus.i_init && w_last) begin
                    r_misalign <= w_misalign_nxt;
                end
            end
        end
    end

    assign bus.o_lsb      = r_lsb;
    assign bus.o_dbus_adr = {r_data[31:2], 2'b00};
    assign bus.o_q        = r_data[B-1:0];
    assign bus.o_done     = r_done;
    assign bus.o_misalign = r_misalign;
endmodule

// File: tb/tb_serv_bufreg_par.sv
module tb_serv_bufreg_par;
    localparam int W = 35; // {misalign, lsb[1:0], dbus_adr[31:0]}

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serv_bufreg_par_if #(.B(1)) bus1 ();
    serv_bufreg_par_if #(.B(2)) bus2 ();
    serv_bufreg_par_if #(.B(4)) bus4 ();
    serv_bufreg_par_if #(.B(8)) bus8 ();

    serv_bufreg_par #(.B(1)) u_b1 (.i_clk(clk), .i_rst(rst), .bus(bus1));
    serv_bufreg_par #(.B(2)) u_b2 (.i_clk(clk), .i_rst(rst), .bus(bus2));
    serv_bufreg_par #(.B(4)) u_b4 (.i_clk(clk), .i_rst(rst), .bus(bus4));
    serv_bufreg_par #(.B(8)) u_b8 (.i_clk(clk), .i_rst(rst), .bus(bus8));

    logic [W-1:0] exp_q1[$];
    logic [W-1:0] exp_q2[$];
    logic [W-1:0] exp_q4[$];
    logic [W-1:0] exp_q8[$];
    logic [3:0]   oq_q[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic cmp_done(input string nm, input logic [31:0] adr, input logic [1:0] lsb,
                            input logic mis, input logic [W-1:0] e);
        chk({nm, "_adr"}, adr, e[31:0]);
        chk({nm, "_lsb"}, 32'(lsb), 32'(e[33:32]));
        chk({nm, "_misalign"}, 32'(mis), 32'(e[34]));
    endtask

    task automatic chk_zero(input string nm, input logic [31:0] adr, input logic [1:0] lsb,
                            input logic done, input logic mis, input logic [7:0] q);
        chk({nm, "_rst_adr"}, adr, 32'd0);
        chk({nm, "_rst_lsb"}, 32'(lsb), 32'd0);
        chk({nm, "_rst_done"}, 32'(done), 32'd0);
        chk({nm, "_rst_misalign"}, 32'(mis), 32'd0);
        chk({nm, "_rst_q"}, 32'(q), 32'd0);
    endtask

    function automatic logic [W-1:0] pack(input logic mis, input logic [1:0] lsb,
                                          input logic [31:0] adr);
        return {mis, lsb, adr};
    endfunction

    // Drive one beat's worth of inputs onto the selected instance.
    task automatic set_bus(input int w, input logic en, input logic init, input logic loop,
                           input logic clr, input logic [1:0] size,
                           input logic [31:0] rs1, input logic [31:0] imm);
        case (w)
            1: begin
                bus1.i_en = en; bus1.i_init = init; bus1.i_loop = loop;
                bus1.i_rs1 = rs1[0:0]; bus1.i_imm = imm[0:0];
                bus1.i_rs1_en = 1'b1; bus1.i_imm_en = 1'b1;
                bus1.i_clr_lsb = clr; bus1.i_size = size;
            end
            2: begin
                bus2.i_en = en; bus2.i_init = init; bus2.i_loop = loop;
                bus2.i_rs1 = rs1[1:0]; bus2.i_imm = imm[1:0];
                bus2.i_rs1_en = 1'b1; bus2.i_imm_en = 1'b1;
                bus2.i_clr_lsb = clr; bus2.i_size = size;
            end
            4: begin
                bus4.i_en = en; bus4.i_init = init; bus4.i_loop = loop;
                bus4.i_rs1 = rs1[3:0]; bus4.i_imm = imm[3:0];
                bus4.i_rs1_en = 1'b1; bus4.i_imm_en = 1'b1;
                bus4.i_clr_lsb = clr; bus4.i_size = size;
            end
            default: begin
                bus8.i_en = en; bus8.i_init = init; bus8.i_loop = loop;
                bus8.i_rs1 = rs1[7:0]; bus8.i_imm = imm[7:0];
                bus8.i_rs1_en = 1'b1; bus8.i_imm_en = 1'b1;
                bus8.i_clr_lsb = clr; bus8.i_size = size;
            end
        endcase
    endtask

    task automatic run_beats(input int w, input int nbeats, input logic init, input logic loop,
                             input logic clr, input logic [1:0] size,
                             input logic [31:0] rs1, input logic [31:0] imm);
        logic [31:0] r;
        logic [31:0] i;
        r = rs1;
        i = imm;
        for (int k = 0; k < nbeats; k++) begin
            set_bus(w, 1'b1, init, loop, clr, size, r, i);
            @(posedge clk);
            #1;
            r = r >> w;
            i = i >> w;
        end
        set_bus(w, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    endtask

    task automatic run_pass(input int w, input logic init, input logic loop, input logic clr,
                            input logic [1:0] size, input logic [31:0] rs1, input logic [31:0] imm);
        run_beats(w, 32 / w, init, loop, clr, size, rs1, imm);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every o_done pulse against the scoreboard, and the
    // serial output of the B=4 instance against its expected beat stream.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst) begin
            if (bus1.o_done) begin
                if (exp_q1.size() == 0) chk("b1_unexpected_done", 32'(bus1.o_done), 32'd0);
                else begin
                    e = exp_q1.pop_front();
                    cmp_done("b1", bus1.o_dbus_adr, bus1.o_lsb, bus1.o_misalign, e);
                end
            end
            if (bus2.o_done) begin
                if (exp_q2.size() == 0) chk("b2_unexpected_done", 32'(bus2.o_done), 32'd0);
                else begin
                    e = exp_q2.pop_front();
                    cmp_done("b2", bus2.o_dbus_adr, bus2.o_lsb, bus2.o_misalign, e);
                end
            end
            if (bus4.o_done) begin
                if (exp_q4.size() == 0) chk("b4_unexpected_done", 32'(bus4.o_done), 32'd0);
                else begin
                    e = exp_q4.pop_front();
                    cmp_done("b4", bus4.o_dbus_adr, bus4.o_lsb, bus4.o_misalign, e);
                end
            end
            if (bus8.o_done) begin
                if (exp_q8.size() == 0) chk("b8_unexpected_done", 32'(bus8.o_done), 32'd0);
                else begin
                    e = exp_q8.pop_front();
                    cmp_done("b8", bus8.o_dbus_adr, bus8.o_lsb, bus8.o_misalign, e);
                end
            end
            if (bus4.i_en && (oq_q.size() != 0)) begin
                chk("b4_loop_q", 32'(bus4.o_q), 32'(oq_q.pop_front()));
            end
        end
    end

    initial begin
        logic [31:0] loop_word;
        for (int w = 1; w <= 8; w = w * 2) begin
            set_bus(w, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("b1", bus1.o_dbus_adr, bus1.o_lsb, bus1.o_done, bus1.o_misalign, 8'(bus1.o_q));
        chk_zero("b8", bus8.o_dbus_adr, bus8.o_lsb, bus8.o_done, bus8.o_misalign, bus8.o_q);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // B=1 address compute: 0x1000 + 0x24
        exp_q1.push_back(pack(1'b0, 2'b00, 32'h0000_1024));
        run_pass(1, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_1000, 32'h0000_0024);

        // B=4 overflow, then a fresh pass must start with carry 0 (1+1 = 2)
        exp_q4.push_back(pack(1'b0, 2'b00, 32'h0000_0000));
        run_pass(4, 1'b1, 1'b0, 1'b0, 2'b10, 32'hFFFF_FFFF, 32'h0000_0001);
        exp_q4.push_back(pack(1'b1, 2'b10, 32'h0000_0000));
        run_pass(4, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0001, 32'h0000_0001);

        // B=2 JALR: bit 0 cleared on imm only
        exp_q2.push_back(pack(1'b1, 2'b11, 32'h0000_0100));
        run_pass(2, 1'b1, 1'b0, 1'b1, 2'b01, 32'h0000_0103, 32'h0000_0000);
        exp_q2.push_back(pack(1'b0, 2'b10, 32'h0000_0100));
        run_pass(2, 1'b1, 1'b0, 1'b1, 2'b01, 32'h0000_0000, 32'h0000_0103);

        // B=8 misalignment; a LOOP pass in between must leave the flag alone
        exp_q8.push_back(pack(1'b1, 2'b01, 32'h0000_2000));
        run_pass(8, 1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_2000, 32'h0000_0001);
        exp_q8.push_back(pack(1'b1, 2'b01, 32'h0000_2000));
        run_pass(8, 1'b0, 1'b1, 1'b0, 2'b10, 32'h1234_5678, 32'h8765_4321);
        exp_q8.push_back(pack(1'b0, 2'b00, 32'h0000_2004));
        run_pass(8, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_2000, 32'h0000_0004);

        // B=4 load 0xA5A5_0F0F, then recirculate it
        exp_q4.push_back(pack(1'b0, 2'b11, 32'hA5A5_0F0C));
        run_pass(4, 1'b1, 1'b0, 1'b0, 2'b00, 32'hA5A5_0F0F, 32'h0000_0000);
        loop_word = 32'hA5A5_0F0F;
        for (int k = 0; k < 8; k++) begin
            oq_q.push_back(loop_word[3:0]);
            loop_word = loop_word >> 4;
        end
        exp_q4.push_back(pack(1'b0, 2'b11, 32'hA5A5_0F0C));
        run_pass(4, 1'b0, 1'b1, 1'b0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // B=1 reset on beat 5 of an INIT pass, then a clean pass
        run_beats(1, 5, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_1000, 32'h0000_0024);
        set_bus(1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0001, 32'h0000_0001);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_bus(1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        @(negedge clk);
        chk_zero("b1_mid", bus1.o_dbus_adr, bus1.o_lsb, bus1.o_done, bus1.o_misalign, 8'(bus1.o_q));
        @(posedge clk);
        #1;
        exp_q1.push_back(pack(1'b1, 2'b10, 32'h8000_0000));
        run_pass(1, 1'b1, 1'b0, 1'b0, 2'b10, 32'h7FFF_FFFF, 32'h0000_0003);

        repeat (4) @(posedge clk);
        chk("b1_missing_done", 32'(exp_q1.size()), 32'd0);
        chk("b2_missing_done", 32'(exp_q2.size()), 32'd0);
        chk("b4_missing_done", 32'(exp_q4.size()), 32'd0);
        chk("b8_missing_done", 32'(exp_q8.size()), 32'd0);
        chk("b4_loop_q_left", 32'(oq_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
